// File: rtl/generic_dpram_sc.sv
// Single-clock simple dual-port RAM: one write port, one read port, 2^aw x dw.
// The read address is registered and the array is read combinationally, so writes are visible on dout in the same cycle they land (write-first).
module generic_dpram_sc #(
  parameter int aw = 8,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rce,
  input  logic          oe,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] dout,
  input  logic          wce,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] di
);

  localparam int depth = 1 << aw;

  // Contents are deliberately not reset; never-written words read X.
  logic [dw-1:0] mem [0:depth-1];
  logic [aw-1:0] ra_reg;

  always_ff @(posedge clk) begin
    if (!rst && wce && we) begin
      mem[waddr] <= di;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_reg <= '0;
    end else if (rce) begin
      ra_reg <= raddr;
    end
  end

  // Reading through the registered address keeps dout tracking writes to ra_reg.
  assign dout = oe ? mem[ra_reg] : '0;

endmodule

// File: tb/tb_generic_dpram_sc.sv
// Bench for generic_dpram_sc: directed cases plus random traffic against a behavioural memory model,
// and a second 16x32 instance for the parameter sweep.
module tb_generic_dpram_sc;

  logic       clk = 1'b0;
  logic       rst, rce, oe, wce, we;
  logic [7:0] raddr, waddr, di;
  logic [7:0] dout;

  logic        w_rst, w_rce, w_oe, w_wce, w_we;
  logic [3:0]  w_raddr, w_waddr;
  logic [31:0] w_di, w_dout;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Behavioural model: memory image, which words hold a defined value, and the captured read address.
  logic [7:0] m_mem [256];
  bit         m_val [256];
  int         m_ra = 0;

  always #5 clk = ~clk;

  generic_dpram_sc #(.aw(8), .dw(8)) dut (
    .clk(clk), .rst(rst), .rce(rce), .oe(oe), .raddr(raddr), .dout(dout),
    .wce(wce), .we(we), .waddr(waddr), .di(di)
  );

  generic_dpram_sc #(.aw(4), .dw(32)) dut_wide (
    .clk(clk), .rst(w_rst), .rce(w_rce), .oe(w_oe), .raddr(w_raddr), .dout(w_dout),
    .wce(w_wce), .we(w_we), .waddr(w_waddr), .di(w_di)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then apply the same rules to the model.
  task automatic cyc(input bit r, input bit wc, input bit w, input logic [7:0] wa,
                     input logic [7:0] d, input bit rc, input logic [7:0] rd, input bit o);
    rst = r; wce = wc; we = w; waddr = wa; di = d; rce = rc; raddr = rd; oe = o;
    @(posedge clk);
    if (!r && wc && w) begin
      m_mem[wa] = d;
      m_val[wa] = 1'b1;
    end
    if (r) m_ra = 0;
    else if (rc) m_ra = int'(rd);
    #1;
  endtask

  // Continuous check: whenever the model knows what dout must be, compare it.
  always @(negedge clk) begin
    if (chk_on) begin
      if (!oe) chk("gated", {24'h0, dout}, 32'h0);
      else if (m_val[m_ra]) chk("model", {24'h0, dout}, {24'h0, m_mem[m_ra]});
    end
  end

  initial begin
    w_rst = 1'b1; w_rce = 1'b0; w_oe = 1'b0; w_wce = 1'b0; w_we = 1'b0;
    w_raddr = '0; w_waddr = '0; w_di = '0;

    // Reset then write 0xA5 to address 0 while reading address 0.
    cyc(1, 0, 0, 8'd0, 8'd0, 0, 8'd0, 0);
    cyc(1, 0, 0, 8'd0, 8'd0, 0, 8'd0, 0);
    chk("reset_oe0", {24'h0, dout}, 32'h0);
    chk_on = 1'b1;
    cyc(0, 1, 1, 8'd0, 8'hA5, 1, 8'd0, 1);
    chk("first_write", {24'h0, dout}, 32'hA5);

    // Sequential fill then readback, including wrap from 255 back to 0.
    for (int i = 0; i < 256; i++) cyc(0, 1, 1, 8'(i), 8'(i) ^ 8'h3C, 0, 8'd0, 1);
    for (int i = 0; i < 256; i++) begin
      cyc(0, 0, 0, 8'd0, 8'd0, 1, 8'(i), 1);
      if (i == 0 || i == 128 || i == 255) chk("fill_read", {24'h0, dout}, 32'(i ^ 'h3C));
    end
    cyc(0, 0, 0, 8'd0, 8'd0, 1, 8'd0, 1);
    chk("wrap_read0", {24'h0, dout}, 32'h3C);

    // Collisions: different address leaves dout alone, same address is write-first.
    cyc(0, 1, 1, 8'd7, 8'h11, 0, 8'd0, 1);
    cyc(0, 1, 1, 8'd8, 8'h77, 1, 8'd7, 1);
    chk("coll_diff", {24'h0, dout}, 32'h11);
    cyc(0, 1, 1, 8'd7, 8'h22, 1, 8'd7, 1);
    chk("coll_same", {24'h0, dout}, 32'h22);

    // Enables.
    cyc(0, 0, 1, 8'd7, 8'h99, 1, 8'd7, 1);
    chk("wce_off", {24'h0, dout}, 32'h22);
    cyc(0, 0, 0, 8'd0, 8'd0, 1, 8'd3, 1);
    cyc(0, 0, 0, 8'd0, 8'd0, 0, 8'd4, 1);
    chk("rce_hold", {24'h0, dout}, 32'h3F);
    oe = 1'b0; #1;
    chk("oe_low", {24'h0, dout}, 32'h0);
    oe = 1'b1; #1;
    chk("oe_high", {24'h0, dout}, 32'h3F);

    // Reset mid-operation drops the concurrent write and keeps contents.
    cyc(0, 1, 1, 8'd5, 8'h5A, 1, 8'd5, 1);
    chk("mid_pre", {24'h0, dout}, 32'h5A);
    cyc(1, 1, 1, 8'd5, 8'hFF, 1, 8'd9, 1);
    chk("mid_rst_ra0", {24'h0, dout}, 32'h3C);
    cyc(0, 0, 0, 8'd0, 8'd0, 1, 8'd5, 1);
    chk("mid_post", {24'h0, dout}, 32'h5A);

    // Random traffic, concentrated on a small window so collisions are frequent.
    for (int n = 0; n < 3000; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          narrow ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)), 8'($urandom),
          $urandom_range(0, 3) != 0,
          narrow ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)),
          $urandom_range(0, 7) != 0);
    end

    // Parameter sweep instance: aw=4, dw=32.
    @(posedge clk); #1;
    w_rst = 1'b0; w_oe = 1'b1; w_wce = 1'b1; w_we = 1'b1; w_waddr = 4'd15; w_di = 32'hDEADBEEF;
    @(posedge clk); #1;
    w_wce = 1'b0; w_we = 1'b0; w_rce = 1'b1; w_raddr = 4'd15;
    @(posedge clk); #1;
    chk("wide_read15", w_dout, 32'hDEADBEEF);
    w_oe = 1'b0; #1;
    chk("wide_oe_low", w_dout, 32'h0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
